rv32_uni_exec_ctrl: RTL and testbench
=====================================

# rv32_uni_exec_ctrl

Single-cycle RV32I(M) execution/control core for the uniciclo datapath. Decodes the fetched instruction into datapath control signals, computes the ALU result and the branch decision, and owns the PC register and next-PC selection. The register file, immediate generator and memory load/store units stay outside this block.

## Interface
- No parameters. Shared encodings come from the package.
- iCLK in 1: system clock; the PC updates on the rising edge.
- iRST_N in 1: asynchronous, active-low reset.
- iInitialPC in 32: PC value loaded while in reset.
- iInstr in 32: current instruction word, fetched from oPC.
- iRead1, iRead2 in 32: rs1/rs2 register-file read data.
- iImm in 32: sign-extended immediate from the external ImmGen.
- oPC out 32: current PC.
- oNextPC out 32: PC value to be loaded at the next edge.
- oPC4 out 32: oPC+4.
- oALUResult out 32: ALU output. Also used as the data memory address.
- oRegWrite, oMemRead, oMemWrite out 1: write-enable and memory strobes.
- oMem2Reg out 2: write-back select. 00 ALU, 01 PC+4, 10 load data.
- oOrigPC out 2: next-PC select. 00 PC+4, 01 conditional branch, 10 jal, 11 jalr.
- oBranch out 1: branch-condition result.

## Operation
- Opcode decode (fields not listed are 0; ALU op is ADD unless stated):
  - LUI: ALU op = LUI (passes B), B=imm, RegWrite.
  - AUIPC: A=PC, B=imm, ADD, RegWrite.
  - JAL: RegWrite, Mem2Reg=01, OrigPC=10.
  - JALR: RegWrite, Mem2Reg=01, OrigPC=11.
  - BRANCH: OrigPC=01, SUB, no write.
  - LOAD: B=imm, MemRead, Mem2Reg=10, RegWrite.
  - STORE: B=imm, MemWrite.
  - OP-IMM: B=imm, RegWrite. funct3 selects ADD/SLT/SLTU/XOR/OR/AND/SLL. For funct3=101, instr[30] selects SRL or SRA.
  - OP: B=rs2, RegWrite. funct7 0000000 gives base ops; 0100000 gives SUB (f3=000) or SRA (f3=101); 0000001 gives M ops.
- Any other opcode, or an OP instruction with an unlisted funct7/funct3 combination, decodes as a NOP: all strobes 0, OrigPC=00.
- ALU operand A is iRead1, or oPC for AUIPC. Operand B is iRead2 or iImm.
- ALU op codes (5 bits): ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, LUI 10, MUL 11, MULH 12, MULHSU 13, MULHU 14, DIV 15, DIVU 16, REM 17, REMU 18. Undefined codes produce 0.
- ALU arithmetic: all results are 32 bits and wrap modulo 2^32. Shift amount is B[4:0]. SLT/SLTU return 1 or 0.
- Branch compare, always on iRead1 vs iRead2, selected by instr[14:12]:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 give oBranch=0.
- Next PC:
  - 00: PC+4.
  - 01: oBranch ? PC+imm : PC+4.
  - 10: PC+imm.
  - 11: (rs1+imm) & ~1.

## Timing
- Decode, ALU, branch compare and next-PC logic are purely combinational from iInstr, iRead1, iRead2, iImm and oPC.
- PC <= oNextPC on every rising iCLK edge while iRST_N=1.
- iRST_N=0 forces PC=iInitialPC immediately, independent of the clock, and holds it there.
- A reset asserted mid-cycle aborts the current instruction: its PC update is lost.
- The first edge after reset release loads oNextPC computed from iInitialPC.
- Reset values:
  - oPC=iInitialPC.
  - All other outputs follow combinationally from oPC and the inputs. There is no additional reset state.

## Configuration
- Macro RV32M_EN.
- When defined: OP with funct7=0000001 decodes to MUL..REMU, implemented as RISC-V specifies:
  - DIV/DIVU by 0 return 0xFFFFFFFF.
  - REM/REMU by 0 return the dividend.
  - DIV 0x80000000 / -1 returns 0x80000000, and REM of the same returns 0.
- When undefined: funct7=0000001 decodes as a NOP, and ALU codes 11–18 produce 0.

## Structure
- Shared package holds:
  - opcode constants;
  - ALU op codes;
  - Mem2Reg and OrigPC encodings;
  - funct3 branch constants.
- One sub-module, rv_alu: combinational, with the 5-bit op code plus A and B as inputs and the result as output. Contains the optional M datapath.
- Decode, branch compare and the PC register live in the top level.

## Test plan
- Reset: iInitialPC=0x00400000, iRST_N pulsed low between edges -> oPC=0x00400000 immediately, with no clock edge needed.
- ADD/SUB: instr 0x002081B3 with rs1=7, rs2=9 -> oALUResult=16, RegWrite=1, next PC=PC+4. Instr 0x402081B3 -> 0xFFFFFFFE.
- Branches: BLT with rs1=0xFFFFFFFF, rs2=1, imm=-8 -> oBranch=1, PC decreases by 8. BLTU with the same operands -> oBranch=0, PC+4.
- JALR: rs1=0x1003, imm=4 -> next PC=0x1006, Mem2Reg=01, RegWrite=1.
- Load/store: LW with rs1=0x10010000, imm=8 -> oALUResult=0x10010008, MemRead=1, Mem2Reg=10. SW -> MemWrite=1, RegWrite=0.
- M extension, with RV32M_EN defined:
  - DIV 7/0 -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - Same tests without the macro -> NOP: strobes 0, PC+4.

Source files
------------

// File: rtl/rv32_uni_exec_ctrl_pkg.sv
// Shared encodings for the uniciclo execution/control core: opcodes, ALU ops,
// write-back and next-PC selects, branch funct3 values.
package rv32_uni_exec_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_LUI    = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } aluOp_t;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_PC4  = 2'b01;
    localparam logic [1:0] M2R_LOAD = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Base integer op from funct3; sraSel only matters for the right shifts.
    function automatic logic [4:0] baseAluOp(input logic [2:0] funct3, input logic sraSel);
        case (funct3)
            3'b000:  baseAluOp = ALU_ADD;
            3'b001:  baseAluOp = ALU_SLL;
            3'b010:  baseAluOp = ALU_SLT;
            3'b011:  baseAluOp = ALU_SLTU;
            3'b100:  baseAluOp = ALU_XOR;
            3'b101:  baseAluOp = sraSel ? ALU_SRA : ALU_SRL;
            3'b110:  baseAluOp = ALU_OR;
            default: baseAluOp = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32_uni_exec_ctrl_alu.sv
// Combinational RV32I ALU; the M-extension datapath is present only when
// RV32M_EN is defined, otherwise codes 11-18 yield zero.
module rv_alu
    import rv32_uni_exec_ctrl_pkg::*;
(
    input  logic [4:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    output logic [31:0] oResult
);

`ifdef RV32M_EN
    logic [63:0] prodSS, prodSU, prodUU;
    logic [63:0] unusedProdLo;
    logic        divZero, signedOvf;
    logic [31:0] divisorS, divisorU, quotS, quotU, remS, remU;

    assign prodSS = {{32{iA[31]}}, iA} * {{32{iB[31]}}, iB};
    assign prodSU = {{32{iA[31]}}, iA} * {32'b0, iB};
    assign prodUU = {32'b0, iA} * {32'b0, iB};
    assign unusedProdLo = {prodSS[31:0], prodSU[31:0]};

    // Divisors are steered away from 0 and the signed overflow pair so the
    // dividers never see an undefined case; the results are patched below.
    assign divZero   = (iB == 32'd0);
    assign signedOvf = (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);
    assign divisorS  = (divZero || signedOvf) ? 32'd1 : iB;
    assign divisorU  = divZero ? 32'd1 : iB;
    assign quotS     = $signed(iA) / $signed(divisorS);
    assign remS      = $signed(iA) % $signed(divisorS);
    assign quotU     = iA / divisorU;
    assign remU      = iA % divisorU;
`endif

    always_comb begin
        oResult = 32'd0;
        case (iOp)
            ALU_ADD:    oResult = iA + iB;
            ALU_SUB:    oResult = iA - iB;
            ALU_AND:    oResult = iA & iB;
            ALU_OR:     oResult = iA | iB;
            ALU_XOR:    oResult = iA ^ iB;
            ALU_SLL:    oResult = iA << iB[4:0];
            ALU_SRL:    oResult = iA >> iB[4:0];
            ALU_SRA:    oResult = $signed(iA) >>> iB[4:0];
            ALU_SLT:    oResult = {31'd0, $signed(iA) < $signed(iB)};
            ALU_SLTU:   oResult = {31'd0, iA < iB};
            ALU_LUI:    oResult = iB;
`ifdef RV32M_EN
            ALU_MUL:    oResult = prodUU[31:0];
            ALU_MULH:   oResult = prodSS[63:32];
            ALU_MULHSU: oResult = prodSU[63:32];
            ALU_MULHU:  oResult = prodUU[63:32];
            ALU_DIV:    oResult = divZero ? 32'hFFFF_FFFF : (signedOvf ? 32'h8000_0000 : quotS);
            ALU_DIVU:   oResult = divZero ? 32'hFFFF_FFFF : quotU;
            ALU_REM:    oResult = divZero ? iA : (signedOvf ? 32'd0 : remS);
            ALU_REMU:   oResult = divZero ? iA : remU;
`endif
            default:    oResult = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv32_uni_exec_ctrl.sv
// Single-cycle RV32I(M) decode, ALU, branch compare and PC register.
// Defining RV32M_EN enables decode of the M extension (funct7=0000001).
module rv32_uni_exec_ctrl
    import rv32_uni_exec_ctrl_pkg::*;
(
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [31:0] iInitialPC,
    input  logic [31:0] iInstr,
    input  logic [31:0] iRead1,
    input  logic [31:0] iRead2,
    input  logic [31:0] iImm,
    output logic [31:0] oPC,
    output logic [31:0] oNextPC,
    output logic [31:0] oPC4,
    output logic [31:0] oALUResult,
    output logic        oRegWrite,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic [1:0]  oMem2Reg,
    output logic [1:0]  oOrigPC,
    output logic        oBranch
);

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  aluOp;
    logic        aluSrcA, aluSrcB;
    logic [31:0] pcReg, aluA, aluB;
    logic        unusedInstrBits;

    assign opcode = iInstr[6:0];
    assign funct3 = iInstr[14:12];
    assign funct7 = iInstr[31:25];
    // Register indices are consumed by the external register file.
    assign unusedInstrBits = ^{iInstr[24:15], iInstr[11:7]};

    always_comb begin
        aluOp     = ALU_ADD;
        aluSrcA   = 1'b0;
        aluSrcB   = 1'b0;
        oRegWrite = 1'b0;
        oMemRead  = 1'b0;
        oMemWrite = 1'b0;
        oMem2Reg  = M2R_ALU;
        oOrigPC   = PC_PLUS4;
        case (opcode)
            OPC_LUI:    begin aluOp = ALU_LUI; aluSrcB = 1'b1; oRegWrite = 1'b1; end
            OPC_AUIPC:  begin aluSrcA = 1'b1; aluSrcB = 1'b1; oRegWrite = 1'b1; end
            OPC_JAL:    begin oRegWrite = 1'b1; oMem2Reg = M2R_PC4; oOrigPC = PC_JAL; end
            OPC_JALR:   begin oRegWrite = 1'b1; oMem2Reg = M2R_PC4; oOrigPC = PC_JALR; end
            OPC_BRANCH: begin aluOp = ALU_SUB; oOrigPC = PC_BRANCH; end
            OPC_LOAD:   begin aluSrcB = 1'b1; oMemRead = 1'b1; oMem2Reg = M2R_LOAD; oRegWrite = 1'b1; end
            OPC_STORE:  begin aluSrcB = 1'b1; oMemWrite = 1'b1; end
            OPC_OPIMM:  begin
                aluSrcB   = 1'b1;
                oRegWrite = 1'b1;
                aluOp     = baseAluOp(funct3, iInstr[30]);
            end
            OPC_OP: begin
                case (funct7)
                    7'b0000000: begin oRegWrite = 1'b1; aluOp = baseAluOp(funct3, 1'b0); end
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            oRegWrite = 1'b1;
                            aluOp     = ALU_SUB;
                        end else if (funct3 == 3'b101) begin
                            oRegWrite = 1'b1;
                            aluOp     = ALU_SRA;
                        end
                    end
`ifdef RV32M_EN
                    // MUL..REMU are contiguous codes ordered like funct3.
                    7'b0000001: begin oRegWrite = 1'b1; aluOp = 5'(ALU_MUL) + {2'b00, funct3}; end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign aluA = aluSrcA ? pcReg : iRead1;
    assign aluB = aluSrcB ? iImm  : iRead2;

    rv_alu uAlu (
        .iOp     (aluOp),
        .iA      (aluA),
        .iB      (aluB),
        .oResult (oALUResult)
    );

    always_comb begin
        oBranch = 1'b0;
        case (funct3)
            F3_BEQ:  oBranch = (iRead1 == iRead2);
            F3_BNE:  oBranch = (iRead1 != iRead2);
            F3_BLT:  oBranch = ($signed(iRead1) <  $signed(iRead2));
            F3_BGE:  oBranch = ($signed(iRead1) >= $signed(iRead2));
            F3_BLTU: oBranch = (iRead1 <  iRead2);
            F3_BGEU: oBranch = (iRead1 >= iRead2);
            default: oBranch = 1'b0;
        endcase
    end

    assign oPC  = pcReg;
    assign oPC4 = pcReg + 32'd4;

    always_comb begin
        oNextPC = oPC4;
        case (oOrigPC)
            PC_BRANCH: oNextPC = oBranch ? (pcReg + iImm) : oPC4;
            PC_JAL:    oNextPC = pcReg + iImm;
            PC_JALR:   oNextPC = (iRead1 + iImm) & ~32'd1;
            default:   oNextPC = oPC4;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) pcReg <= iInitialPC;
        else         pcReg <= oNextPC;
    end

endmodule

// File: tb/tb_rv32_uni_exec_ctrl.sv
// Bench for rv32_uni_exec_ctrl: directed scenarios plus random instructions
// checked against an instruction-level reference model.
module tb_rv32_uni_exec_ctrl;

    localparam logic [31:0] INIT_PC = 32'h0040_0000;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [31:0] iInitialPC, iInstr, iRead1, iRead2, iImm;
    logic [31:0] oPC, oNextPC, oPC4, oALUResult;
    logic        oRegWrite, oMemRead, oMemWrite, oBranch;
    logic [1:0]  oMem2Reg, oOrigPC;

    int checks = 0;
    int errors = 0;
    logic [31:0] modelPc, expNext;

    rv32_uni_exec_ctrl dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iInitialPC(iInitialPC), .iInstr(iInstr),
        .iRead1(iRead1), .iRead2(iRead2), .iImm(iImm), .oPC(oPC), .oNextPC(oNextPC),
        .oPC4(oPC4), .oALUResult(oALUResult), .oRegWrite(oRegWrite), .oMemRead(oMemRead),
        .oMemWrite(oMemWrite), .oMem2Reg(oMem2Reg), .oOrigPC(oOrigPC), .oBranch(oBranch)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Register-register / register-immediate integer semantics.
    function automatic logic [31:0] intOp(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] mulDiv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub, p;
        longint unsigned pu;
        int ia, ib;
        sa = longint'($signed(a)); sb = longint'($signed(b)); ub = longint'({32'd0, b});
        ia = a; ib = b;
        case (f3)
            3'd0: return a * b;
            3'd1: begin p = sa * sb; return 32'(p >>> 32); end
            3'd2: begin p = sa * ub; return 32'(p >>> 32); end
            3'd3: begin pu = longint'({32'd0, a}) * longint'({32'd0, b}); return 32'(pu >> 32); end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic refModel(input logic [31:0] ins, r1, r2, imm, pc,
                            output logic [31:0] alu, nxt, output logic rw, mr, mw, br,
                            output logic [1:0] m2r, sel);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12]; f7 = ins[31:25];
        alu = r1 + r2; rw = 0; mr = 0; mw = 0; m2r = 0; sel = 0;
        case (f3)
            3'd0: br = (r1 == r2);
            3'd1: br = (r1 != r2);
            3'd4: br = ($signed(r1) < $signed(r2));
            3'd5: br = ($signed(r1) >= $signed(r2));
            3'd6: br = (r1 < r2);
            3'd7: br = (r1 >= r2);
            default: br = 0;
        endcase
        case (ins[6:0])
            7'b0110111: begin alu = imm; rw = 1; end
            7'b0010111: begin alu = pc + imm; rw = 1; end
            7'b1101111: begin rw = 1; m2r = 1; sel = 2; end
            7'b1100111: begin rw = 1; m2r = 1; sel = 3; end
            7'b1100011: begin alu = r1 - r2; sel = 1; end
            7'b0000011: begin alu = r1 + imm; mr = 1; m2r = 2; rw = 1; end
            7'b0100011: begin alu = r1 + imm; mw = 1; end
            7'b0010011: begin alu = intOp(f3, (f3 == 3'd5) && ins[30], r1, imm); rw = 1; end
            7'b0110011: begin
                if (f7 == 7'h00) begin alu = intOp(f3, 1'b0, r1, r2); rw = 1; end
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    alu = intOp(f3, 1'b1, r1, r2); rw = 1;
                end
`ifdef RV32M_EN
                else if (f7 == 7'h01) begin alu = mulDiv(f3, r1, r2); rw = 1; end
`endif
            end
            default: ;
        endcase
        case (sel)
            2'd1: nxt = br ? pc + imm : pc + 4;
            2'd2: nxt = pc + imm;
            2'd3: nxt = (r1 + imm) & 32'hFFFF_FFFE;
            default: nxt = pc + 4;
        endcase
    endtask

    // Drive one instruction and compare every output with the model (no clock).
    task automatic apply(input string tag, input logic [31:0] ins, r1, r2, imm);
        logic [31:0] eAlu;
        logic eRw, eMr, eMw, eBr;
        logic [1:0] eM2r, eSel;
        iInstr = ins; iRead1 = r1; iRead2 = r2; iImm = imm;
        #1;
        refModel(ins, r1, r2, imm, modelPc, eAlu, expNext, eRw, eMr, eMw, eBr, eM2r, eSel);
        check({tag, ".pc"},     oPC,        modelPc);
        check({tag, ".pc4"},    oPC4,       modelPc + 32'd4);
        check({tag, ".alu"},    oALUResult, eAlu);
        check({tag, ".next"},   oNextPC,    expNext);
        check({tag, ".rw"},     32'(oRegWrite), 32'(eRw));
        check({tag, ".mr"},     32'(oMemRead),  32'(eMr));
        check({tag, ".mw"},     32'(oMemWrite), 32'(eMw));
        check({tag, ".br"},     32'(oBranch),   32'(eBr));
        check({tag, ".m2r"},    32'(oMem2Reg),  32'(eM2r));
        check({tag, ".sel"},    32'(oOrigPC),   32'(eSel));
    endtask

    task automatic tick(input string tag);
        @(posedge iCLK);
        modelPc = expNext;
        #1;
        check({tag, ".pcupd"}, oPC, modelPc);
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ins, r1, r2, imm, pcBefore;
        logic [6:0]  opList [10];
        opList = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                   7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};

        iRST_N = 1'b1; iInitialPC = INIT_PC;
        iInstr = 32'h0000_0013; iRead1 = 0; iRead2 = 0; iImm = 0;
        #2 iRST_N = 1'b0;
        #1 check("reset.pc", oPC, INIT_PC);
        @(negedge iCLK);
        check("reset.hold", oPC, INIT_PC);
        @(negedge iCLK);
        iRST_N = 1'b1;
        modelPc = INIT_PC;

        apply("add", 32'h0020_81B3, 32'd7, 32'd9, 32'd0);
        check("add.c", oALUResult, 32'd16);
        check("add.rwc", 32'(oRegWrite), 32'd1);
        check("add.nextc", oNextPC, INIT_PC + 32'd4);
        tick("add");

        apply("sub", 32'h4020_81B3, 32'd7, 32'd9, 32'd0);
        check("sub.c", oALUResult, 32'hFFFF_FFFE);
        tick("sub");

        pcBefore = modelPc;
        apply("blt", {7'd0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011}, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
        check("blt.brc", 32'(oBranch), 32'd1);
        check("blt.nextc", oNextPC, pcBefore - 32'd8);
        tick("blt");

        pcBefore = modelPc;
        apply("bltu", {7'd0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011}, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8);
        check("bltu.brc", 32'(oBranch), 32'd0);
        check("bltu.nextc", oNextPC, pcBefore + 32'd4);
        tick("bltu");

        apply("jalr", {12'd4, 5'd1, 3'b000, 5'd1, 7'b1100111}, 32'h0000_1003, 32'd0, 32'd4);
        check("jalr.nextc", oNextPC, 32'h0000_1006);
        check("jalr.m2rc", 32'(oMem2Reg), 32'd1);
        tick("jalr");

        apply("lw", {12'd8, 5'd1, 3'b010, 5'd3, 7'b0000011}, 32'h1001_0000, 32'd0, 32'd8);
        check("lw.aluc", oALUResult, 32'h1001_0008);
        check("lw.mrc", 32'(oMemRead), 32'd1);
        check("lw.m2rc", 32'(oMem2Reg), 32'd2);
        tick("lw");

        apply("sw", {7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011}, 32'h1001_0000, 32'd5, 32'd8);
        check("sw.mwc", 32'(oMemWrite), 32'd1);
        check("sw.rwc", 32'(oRegWrite), 32'd0);
        tick("sw");

        pcBefore = modelPc;
        apply("div0", {7'd1, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011}, 32'd7, 32'd0, 32'd0);
`ifdef RV32M_EN
        check("div0.c", oALUResult, 32'hFFFF_FFFF);
        check("div0.rwc", 32'(oRegWrite), 32'd1);
`else
        check("div0.nop", 32'(oRegWrite), 32'd0);
        check("div0.nextc", oNextPC, pcBefore + 32'd4);
`endif
        tick("div0");

        apply("mulhu", {7'd1, 5'd2, 5'd1, 3'b011, 5'd3, 7'b0110011}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
`ifdef RV32M_EN
        check("mulhu.c", oALUResult, 32'hFFFF_FFFE);
`else
        check("mulhu.nop", 32'(oRegWrite), 32'd0);
`endif
        tick("mulhu");

        apply("divovf", {7'd1, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011}, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        tick("divovf");
        apply("removf", {7'd1, 5'd2, 5'd1, 3'b110, 5'd3, 7'b0110011}, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        tick("removf");
        apply("srai", {7'h20, 5'd4, 5'd1, 3'b101, 5'd3, 7'b0010011}, 32'h8000_00F0, 32'd0, 32'h0000_0404);
        tick("srai");

        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            ins[6:0] = opList[$urandom_range(0, 9)];
            if (ins[6:0] == 7'b0110011) begin
                case ($urandom_range(0, 3))
                    0: ins[31:25] = 7'h00;
                    1: ins[31:25] = 7'h20;
                    2: ins[31:25] = 7'h01;
                    default: ;
                endcase
            end
            r1 = pickVal();
            r2 = ($urandom_range(0, 7) == 0) ? r1 : pickVal();
            imm = $urandom;
            if ($urandom_range(0, 1) == 1) imm = {{20{imm[11]}}, imm[11:0]};
            apply("rnd", ins, r1, r2, imm);
            tick("rnd");

            if (i == 200) begin
                // Reset between edges: the pending update is dropped and PC snaps back.
                apply("abort", 32'h0020_81B3, 32'd1, 32'd2, 32'd0);
                #2 iRST_N = 1'b0;
                #1 check("abort.pc", oPC, INIT_PC);
                #1 iRST_N = 1'b1;
                modelPc = INIT_PC;
                apply("postrst", 32'h0020_81B3, 32'd3, 32'd4, 32'd0);
                check("postrst.nextc", oNextPC, INIT_PC + 32'd4);
                tick("postrst");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
